// File: rtl/sti_sbox_pipe.sv
// ---------------------------------------------------------------------------
// sti_sbox_pipe
//
// Pipelined threshold-implementation S-box evaluator. A masked value is
// carried as NS shares of W bits. Each of the R rounds evaluates NS*W
// single-bit component functions. Each function reads a runtime-loaded
// truth table, indexed by every share except the one it produces, so a
// round never combines all shares of a secret (non-completeness). A
// register after each round stops glitches from propagating into the next
// round.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake; in carries NS packed shares
//   in                    share k at [k*W+W-1:k*W]
//   out_valid / out_ready output handshake; out uses the same packing
//   out                   output shares, driven from the last stage register
//   cfg_we                table write strobe
//   cfg_addr              {round, share, bit, entry}; entry in the LSBs
//   cfg_wdata             table bit to write
//   cfg_commit            tables complete, leave CFG and enter RUN
//   cfg_ready             table write permitted (pipeline empty)
//   tbl_valid             high while in RUN
// ---------------------------------------------------------------------------
module sti_sbox_pipe #(
  parameter int W  = 4,
  parameter int NS = 3,
  parameter int R  = 2,
  parameter int AW = (NS - 1) * W,
  parameter int CW = $clog2(R) + $clog2(NS) + $clog2(W) + AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NS*W-1:0] in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NS*W-1:0] out,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_addr,
  input  logic            cfg_wdata,
  input  logic            cfg_commit,
  output logic            cfg_ready,
  output logic            tbl_valid
);

  localparam int RB  = $clog2(R);
  localparam int SB  = $clog2(NS);
  localparam int BB  = $clog2(W);
  localparam int NE  = 1 << AW;
  localparam int TSZ = R * NS * W * NE;
  localparam int IW  = $clog2(TSZ);

  localparam logic [0:0] S_CFG = 1'b0;
  localparam logic [0:0] S_RUN = 1'b1;

  // Flat table position of (round, share, bit, entry). NS need not be a
  // power of two, so the address fields are not simply concatenated.
  function automatic logic [IW-1:0] tbl_idx(input int rnd, input int shr,
                                            input int bt, input int ent);
    return IW'(((rnd * NS + shr) * W + bt) * NE + ent);
  endfunction

  // Table index for a component function of share i: the other shares in
  // order (i+1)%NS, (i+2)%NS, ... with (i+1)%NS in the MSBs. Share i itself
  // is never read.
  function automatic logic [AW-1:0] nc_index(input logic [NS*W-1:0] v,
                                             input int i);
    logic [AW-1:0] a;
    a = '0;
    for (int j = 1; j < NS; j++) begin
      a[(NS-1-j)*W +: W] = v[((i + j) % NS)*W +: W];
    end
    return a;
  endfunction

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [R-1:0]    r_vld;
  logic [NS*W-1:0] r_dat  [R];
  logic [NS*W-1:0] w_rin  [R];
  logic [NS*W-1:0] w_rout [R];
  logic [R-1:0]    w_load;
  logic [R-1:0]    w_up_vld;
  logic            w_in_fire;
  logic            w_wr_acc;
  logic            w_wr_in_range;
  logic [IW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_wr_entry;
  logic [BB-1:0]   w_wr_bit;
  logic [SB-1:0]   w_wr_share;
  logic [RB-1:0]   w_wr_round;
  logic            r_tbl [TSZ];

  // Address field split and write qualification
  assign w_wr_entry    = cfg_addr[AW-1:0];
  assign w_wr_bit      = cfg_addr[AW +: BB];
  assign w_wr_share    = cfg_addr[AW+BB +: SB];
  assign w_wr_round    = cfg_addr[AW+BB+SB +: RB];
  assign w_wr_in_range = (int'(w_wr_share) < NS) && (int'(w_wr_round) < R);
  assign w_wr_idx      = tbl_idx(int'(w_wr_round), int'(w_wr_share),
                                 int'(w_wr_bit), int'(w_wr_entry));
  assign cfg_ready     = ~|r_vld;
  assign w_wr_acc      = cfg_we & cfg_ready;

  // Table storage: deliberately not reset so tables survive rst and only a
  // commit is needed to resume. Addresses naming a nonexistent share or
  // round are ignored.
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_wr_in_range) begin
      r_tbl[w_wr_idx] <= cfg_wdata;
    end
  end

  // Stage k may load when some stage at or after k is empty, or the output
  // is being taken: the whole tail then shifts by one.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < R; k++) begin
      w_load[k] = out_ready;
      for (int j = k; j < R; j++) begin
        w_load[k] = w_load[k] | ~r_vld[j];
      end
    end
  end

  // A write strobe blocks input in its cycle even when the write is dropped.
  assign in_ready  = (r_state == S_RUN) && !cfg_we && w_load[0];
  assign w_in_fire = in_valid && in_ready;
  assign tbl_valid = (r_state == S_RUN);
  assign out_valid = r_vld[R-1];
  assign out       = r_dat[R-1];

  assign w_rin[0]    = in;
  assign w_up_vld[0] = w_in_fire;
  for (genvar gk = 1; gk < R; gk++) begin : g_chain
    assign w_rin[gk]    = r_dat[gk-1];
    assign w_up_vld[gk] = r_vld[gk-1];
  end

  for (genvar gr = 0; gr < R; gr++) begin : g_round
    logic [NS*W-1:0] w_res;
    // Component functions of one round, read straight from the table
    always_comb begin
      w_res = '0;
      for (int i = 0; i < NS; i++) begin
        for (int b = 0; b < W; b++) begin
          w_res[i*W+b] = r_tbl[tbl_idx(gr, i, b, int'(nc_index(w_rin[gr], i)))];
        end
      end
    end
    assign w_rout[gr] = w_res;
  end

  // CFG/RUN next state; an accepted write always returns to CFG
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CFG: begin
        if (w_wr_acc) begin
          w_state_nxt = S_CFG;
        end else if (cfg_commit) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_CFG;
        end
      end
      S_RUN: begin
        if (w_wr_acc) begin
          w_state_nxt = S_CFG;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_CFG;
    endcase
  end

  // State register and round pipeline; reset discards in-flight vectors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CFG;
      r_vld   <= '0;
      for (int k = 0; k < R; k++) begin
        r_dat[k] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      for (int k = 0; k < R; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= w_up_vld[k];
          // Data only moves with a valid vector so out stays put otherwise
          if (w_up_vld[k]) begin
            r_dat[k] <= w_rout[k];
          end
        end
      end
    end
  end

endmodule

// File: doc/sti_sbox_pipe.md
Name: sti_sbox_pipe

Overview:
- Parametrised, pipelined threshold-implementation (TI) S-box evaluator for an NS-share, W-bit masked nibble, computed in R rounds.
- Each round evaluates NS*W single-bit component functions. Each function depends only on the shares other than its own (non-completeness).
- Component tables are runtime-loadable rather than hard-coded, so one block serves any S-box decomposition.
- A register between rounds isolates glitches. A valid/ready interface connects the block to the masked datapath.

Parameters:
- W, 4, bits per share.
- NS, 3, number of shares (3 or 4 supported).
- R, 2, number of decomposition rounds; pipeline depth.
- AW, (NS-1)*W, derived; component-table index width (8 by default).
- CW, clog2(R)+clog2(NS)+clog2(W)+AW, derived; config address width (13 by default).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input share vector valid
- in_ready  out  1  block accepts input this cycle
- in  in  NS*W  shares; share k at [k*W+W-1:k*W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out  out  NS*W  output shares, same packing as in
- cfg_we  in  1  table write strobe
- cfg_addr  in  CW  {round, share, bit, entry}, round in MSBs, entry in LSBs
- cfg_wdata  in  1  table bit
- cfg_commit  in  1  pulse: tables complete, enter RUN
- cfg_ready  out  1  table write permitted this cycle
- tbl_valid  out  1  high in RUN state

Behaviour:
- Reset: state=CFG; tbl_valid=0, in_ready=0, out_valid=0, out=0, all stage valids=0.
- Table contents are NOT reset; they are retained across rst.
- State machine has two states, CFG and RUN.
  - CFG->RUN: on cfg_commit.
  - RUN->CFG: on an accepted table write.
  - cfg_commit in RUN: no effect.
  - Accepted table write in CFG: stays in CFG.
- cfg_ready = pipeline empty (all stage valids 0).
- A write is accepted when cfg_we && cfg_ready. A write with cfg_ready=0 is dropped silently; the table is unchanged.
- Component function for round r, share i, bit b:
  - Output bit = T[r][i][b][a].
  - a is the concatenation of shares (i+1)%NS, (i+2)%NS, ..., (i+NS-1)%NS, with share (i+1)%NS in the MSBs.
  - Share i's own input is never used.
- Round 1 takes its input from in; round r>1 takes its input from the stage r-1 register.
- Pipeline: R stages, each with a data register and a valid flag.
  - Stage k loads when it is empty or stage k+1 is taking its data (stage R: out_ready).
  - Full throughput of 1 vector/cycle when out_ready is held high.
- in_ready = (state==RUN) && !cfg_we && stage-1 can load.
  - cfg_we in the same cycle as in_valid blocks input.
  - Even when that write is dropped, the input is not accepted that cycle.
- Latency: a vector accepted in cycle c appears on out with out_valid=1 in cycle c+R, provided no stall.
- out = stage-R data register; out_valid = stage-R valid.
  - out holds stable while out_valid && !out_ready.
- Order is preserved, nothing is dropped or duplicated, and a maximum of R vectors are in flight.
- rst asserted mid-stream: all in-flight vectors are discarded, out_valid falls asynchronously, and the block returns to CFG.
  - Retained tables require only cfg_commit to resume.
- Table storage: R*NS*W*2^AW bits; a flop array or equivalent is permitted. Read is combinational within the round.

Test Plan:
- Zero/ones tables: load all-0, commit, stream in=12'h5A3 -> out=12'h000 after 2 cycles. Reload all-1, commit, same input -> out=12'hFFF.
- Rotation tables (entry = a[W+b], so output share i = input share i+1), commit:
  - in=12'h321 -> out=12'h213 in cycle c+2.
  - Back-to-back 12'h321, 12'h654 -> outputs 12'h213, 12'h546 on consecutive cycles.
- Backpressure: rotation tables, out_ready=0 while offering 3 vectors.
  - 2 vectors accepted, then in_ready=0 and out is held stable.
  - Release out_ready -> all 3 results emerge in order, none lost.
- Config gating:
  - cfg_we while pipeline holds data -> cfg_ready=0, write dropped, state stays RUN.
  - cfg_we with in_valid on an empty pipeline -> write accepted, input refused, tbl_valid=0 next cycle.
- Reset mid-stream with rotation tables and 2 vectors in flight:
  - rst pulse -> out_valid=0 immediately; in_ready=0 until cfg_commit.
  - After commit with no reload, in=12'h321 -> out=12'h213.
